bldc_drive_sequencer: RTL and testbench
=======================================

# bldc_drive_sequencer

Sequences the drive command for the BLDC PWM stage. The block sits between the I2C register bank and the PWM generator and H-bridge outputs. It accepts target duty/direction/brake commands, ramps the applied duty toward the target at a fixed rate, and forces a zero-duty dead interval before any direction reversal. It also watches encoder activity and latches a stall fault that shuts the drive off until software clears it.

## Interface
Parameters:
- `DUTY_W`, default 8: duty width; 0 = off, 2^DUTY_W−1 = full.
- `RAMP_DIV`, default 256: clocks per ±1 duty step; minimum 1.
- `DEADTIME`, default 64: clocks with the bridge disabled before a direction flip; minimum 1.
- `STALL_MIN`, default 32: duty at or above which the stall watchdog is armed.
- `STALL_TIMEOUT`, default 65535: tick-free armed clocks that trip a fault.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: a new command is presented.
- `cmd_ready` out 1: the command is accepted when `cmd_valid && cmd_ready`.
- `cmd_duty` in DUTY_W: target duty.
- `cmd_dir` in 1: target direction; 1 = forward.
- `cmd_brake` in 1: brake request; when set, `cmd_duty` and `cmd_dir` are ignored.
- `enc_tick` in 1: one-clock pulse per encoder edge, already synchronised.
- `fault_clr` in 1: clears a latched fault.
- `pwm_duty` out DUTY_W: duty applied to the PWM generator.
- `pwm_dir` out 1: bridge direction.
- `pwm_en` out 1: bridge enable.
- `brake` out 1: low-side brake command.
- `fault` out 1: stall fault is latched.
- `busy` out 1: `pwm_duty` differs from the target, or the state is DEAD.

## Operation
States: IDLE, RUN, DEAD, BRAKE, FAULT.

Command handling:
- `cmd_ready` = 1 in every state except FAULT.
- An accepted command overwrites `tgt_duty`, `tgt_dir` and `tgt_brake`.
- An accepted brake command goes to BRAKE from any non-FAULT state on the next edge.

IDLE:
- `pwm_duty` = 0, `pwm_en` = 0.
- Leaves only when `tgt_duty` ≠ 0. Goes to RUN if `tgt_dir` = `pwm_dir`, otherwise to DEAD.

RUN:
- `pwm_en` = 1.
- The prescaler counts 0..RAMP_DIV−1. It is cleared on entry to RUN.
- On each terminal count (one step per terminal count):
  - if `tgt_dir` = `pwm_dir`, `pwm_duty` moves 1 toward `tgt_duty`;
  - otherwise `pwm_duty` moves 1 toward 0.
- Once `pwm_duty` = 0: go to DEAD if `tgt_dir` ≠ `pwm_dir`; go to IDLE if `tgt_duty` = 0.
- Duty never overshoots or wraps. Arithmetic is saturating; there is no sign extension.

DEAD:
- `pwm_en` = 0, `pwm_duty` = 0.
- Counts DEADTIME clocks. On the last clock, `pwm_dir` ← `tgt_dir`.
- Then goes to RUN if `tgt_duty` ≠ 0, else IDLE.
- A command accepted during DEAD updates the target only; the count is not restarted.

BRAKE:
- `brake` = 1, `pwm_en` = 0, `pwm_duty` = 0.
- An accepted non-brake command with `cmd_duty` ≠ 0 exits via the IDLE rules, evaluated on the next edge.
- With `cmd_duty` = 0, the exit goes to IDLE.

Stall watchdog:
- Armed only in RUN with `pwm_duty` ≥ STALL_MIN.
- The counter clears on `enc_tick` or when disarmed.
- When it reaches STALL_TIMEOUT, the block enters FAULT.

FAULT:
- `fault` = 1, `pwm_en` = 0, `pwm_duty` = 0, `brake` = 0.
- Targets are cleared to 0.
- `fault_clr` → IDLE. `fault_clr` is ignored in all other states.

Simultaneous events:
- Fault trip and command acceptance in the same cycle: the fault wins and the command is dropped.
- Brake command and ramp step in the same cycle: the brake wins.

## Timing
- Reset values: `pwm_duty` = 0, `pwm_dir` = 1, `pwm_en` = 0, `brake` = 0, `fault` = 0, `busy` = 0, `cmd_ready` = 1.
  - The state returns to IDLE and all counters and targets are 0.
  - Reset mid-ramp takes effect at the next edge.
- All outputs are registered. An accepted command affects outputs no earlier than the following edge.
- A step that coincides with a command acceptance uses the old target.
- Ramp from 0 to D in the same direction: D·RAMP_DIV clocks after RUN entry.
- Reversal from duty D to duty E: D·RAMP_DIV + DEADTIME + E·RAMP_DIV clocks, plus one clock per state transition.
- Fault timing: `fault` rises on the edge after the STALL_TIMEOUT-th consecutive armed, tick-free clock. `pwm_en` falls on that same edge.

## Structure
- `bldc_pkg` holds the state enum (`drv_state_t`), `DUTY_W`, and the default parameter constants shared with the PWM and I2C register blocks.
- One sub-module, `bldc_stall_watchdog`, holds the counter and compare. Its ports are arm, tick and trip.
- The ramp prescaler and dead counter stay inline.

## Test plan
Bench parameters: RAMP_DIV = 4, DEADTIME = 8, STALL_MIN = 2, STALL_TIMEOUT = 16.
- Ramp up: command duty 10, dir 1 from reset → `pwm_duty` increments every 4 clocks; 10 is reached 40 clocks after RUN entry; `busy` then falls.
- Reversal: while running at 10/fwd, command 6/rev → duty ramps to 0; `pwm_en` = 0 for exactly 8 clocks; `pwm_dir` flips to 0; duty ramps to 6.
- Brake: command brake mid-ramp at duty 5 → the next edge gives `brake` = 1, `pwm_duty` = 0, `pwm_en` = 0; a following command 3/fwd ramps from 0.
- Stall: run at duty 4 with no `enc_tick` → `fault` = 1 after 16 armed clocks, and `cmd_ready` = 0. Pulsing `enc_tick` every 10 clocks prevents the trip.
- Fault clear and reset: `fault_clr` in FAULT → IDLE with all outputs at 0. Asserting `rst` mid-ramp → reset values on the next edge.

Source files
------------

// File: rtl/bldc_pkg.sv
// bldc_pkg: drive-sequencer state type and default constants shared by the BLDC PWM, I2C and drive blocks
package bldc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DEAD, S_BRAKE, S_FAULT} drv_state_t;
  localparam int DUTY_W            = 8;
  localparam int RAMP_DIV_DEF      = 256;
  localparam int DEADTIME_DEF      = 64;
  localparam int STALL_MIN_DEF     = 32;
  localparam int STALL_TIMEOUT_DEF = 65535;
endpackage

// File: rtl/bldc_stall_watchdog.sv
// bldc_stall_watchdog: counts armed clocks without an encoder tick and flags a stall
// Ports: clk/rst; arm enables counting; tick clears the count; trip is high on the
//   TIMEOUT-th consecutive armed tick-free clock, so the owner latches a fault on that edge
module bldc_stall_watchdog #(
  parameter int TIMEOUT = bldc_pkg::STALL_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic tick,
  output logic trip
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign trip = arm && !tick && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (rst || !arm || tick) cnt <= '0;
    else if (cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/bldc_drive_sequencer.sv
// bldc_drive_sequencer: ramps PWM duty toward the commanded target, inserts dead time before reversal, brakes, latches stall faults
// Ports: clk/rst; cmd_valid/cmd_ready with cmd_duty/cmd_dir/cmd_brake carry the target;
//   enc_tick encoder edge pulse; fault_clr clears a latched fault;
//   pwm_duty/pwm_dir/pwm_en/brake drive the bridge; fault flags a stall; busy flags ramp or dead time
module bldc_drive_sequencer #(
  parameter int DUTY_W        = bldc_pkg::DUTY_W,
  parameter int RAMP_DIV      = bldc_pkg::RAMP_DIV_DEF,
  parameter int DEADTIME      = bldc_pkg::DEADTIME_DEF,
  parameter int STALL_MIN     = bldc_pkg::STALL_MIN_DEF,
  parameter int STALL_TIMEOUT = bldc_pkg::STALL_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              cmd_dir,
  input  logic              cmd_brake,
  input  logic              enc_tick,
  input  logic              fault_clr,
  output logic [DUTY_W-1:0] pwm_duty,
  output logic              pwm_dir,
  output logic              pwm_en,
  output logic              brake,
  output logic              fault,
  output logic              busy
);
  import bldc_pkg::*;
  localparam int PW = $clog2(RAMP_DIV + 1);
  localparam int DW = $clog2(DEADTIME + 1);
  drv_state_t state, state_n, idle_next;
  logic [DUTY_W-1:0] duty_n, tgt_duty;
  logic dir_n, tgt_dir, tgt_brake;
  logic [PW-1:0] pre;
  logic [DW-1:0] dcnt;
  logic acc, tc, dead_end, arm, trip;
  assign acc       = cmd_valid && cmd_ready;
  assign tc        = pre == PW'(RAMP_DIV - 1);
  assign dead_end  = dcnt == DW'(DEADTIME - 1);
  assign arm       = state == S_RUN && pwm_duty >= DUTY_W'(STALL_MIN);
  assign idle_next = tgt_duty == '0 ? S_IDLE : tgt_dir == pwm_dir ? S_RUN : S_DEAD;
  assign cmd_ready = state != S_FAULT;
  assign pwm_en    = state == S_RUN;
  assign brake     = state == S_BRAKE;
  assign fault     = state == S_FAULT;
  assign busy      = pwm_duty != tgt_duty || state == S_DEAD;
  bldc_stall_watchdog #(.TIMEOUT(STALL_TIMEOUT)) u_wd (
    .clk  (clk),
    .rst  (rst),
    .arm  (arm),
    .tick (enc_tick),
    .trip (trip)
  );
  always_comb begin
    state_n = state;
    duty_n  = pwm_duty;
    dir_n   = pwm_dir;
    case (state)
      S_IDLE: state_n = idle_next;
      S_RUN:
        if (pwm_duty == '0 && tgt_dir != pwm_dir) state_n = S_DEAD;
        else if (pwm_duty == '0 && tgt_duty == '0) state_n = S_IDLE;
        // a pending reversal always ramps down first; otherwise move toward target
        else if (tc) duty_n = tgt_dir != pwm_dir ? pwm_duty - 1'b1
                            : pwm_duty < tgt_duty ? pwm_duty + 1'b1
                            : pwm_duty > tgt_duty ? pwm_duty - 1'b1 : pwm_duty;
      S_DEAD:
        if (dead_end) begin
          dir_n   = tgt_dir;
          state_n = tgt_duty != '0 ? S_RUN : S_IDLE;
        end
      S_BRAKE: if (!tgt_brake) state_n = idle_next;
      S_FAULT: if (fault_clr) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // brake overrides any ramp step; a stall trip overrides everything
    if (acc && cmd_brake) begin
      state_n = S_BRAKE;
      duty_n  = '0;
    end
    if (trip) begin
      state_n = S_FAULT;
      duty_n  = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pwm_duty  <= '0;
      pwm_dir   <= 1'b1;
      tgt_duty  <= '0;
      tgt_dir   <= 1'b0;
      tgt_brake <= 1'b0;
      pre       <= '0;
      dcnt      <= '0;
    end else begin
      state    <= state_n;
      pwm_duty <= duty_n;
      pwm_dir  <= dir_n;
      // both counters sit at zero outside their state so entry always starts clean
      pre      <= state != S_RUN || tc ? '0 : pre + 1'b1;
      dcnt     <= state != S_DEAD ? '0 : dcnt + 1'b1;
      if (trip) begin
        tgt_duty  <= '0;
        tgt_dir   <= 1'b0;
        tgt_brake <= 1'b0;
      end else if (acc) begin
        tgt_duty  <= cmd_brake ? '0 : cmd_duty;
        tgt_dir   <= cmd_brake ? tgt_dir : cmd_dir;
        tgt_brake <= cmd_brake;
      end
    end
  end
endmodule

// File: tb/tb_bldc_drive_sequencer.sv
// tb_bldc_drive_sequencer: directed scenarios checked cycle-by-cycle against a precomputed output schedule
module tb_bldc_drive_sequencer;
  localparam int RD = 4;
  localparam int TO = 16;
  localparam int NC = 300;
  localparam int LAST_TICK = 181;
  localparam int ARM_START = 179;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_brake = 1'b0, enc_tick = 1'b0, fault_clr = 1'b0;
  logic [7:0] cmd_duty = '0;
  logic cmd_ready, pwm_dir, pwm_en, brake, fault, busy;
  logic [7:0] pwm_duty;
  logic tick_en = 1'b1;
  int cyc = 0;
  int checks = 0, errors = 0, en_low = 0, fault_cyc;
  logic [13:0] exp_v [NC];
  bit exp_ok [NC];
  bldc_drive_sequencer #(
    .DUTY_W(8), .RAMP_DIV(RD), .DEADTIME(8), .STALL_MIN(2), .STALL_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_duty(cmd_duty),
    .cmd_dir(cmd_dir), .cmd_brake(cmd_brake), .enc_tick(enc_tick), .fault_clr(fault_clr),
    .pwm_duty(pwm_duty), .pwm_dir(pwm_dir), .pwm_en(pwm_en), .brake(brake), .fault(fault), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic put(input int c, input int duty, input bit dir, input bit en, input bit brk,
                     input bit flt, input bit bsy, input bit rdy);
    exp_v[c]  = {8'(duty), dir, en, brk, flt, bsy, rdy};
    exp_ok[c] = 1'b1;
  endtask
  task automatic still(input int c0, input int c1, input bit brk, input bit flt, input bit bsy);
    for (int c = c0; c <= c1; c++) put(c, 0, 1'b1, 1'b0, brk, flt, bsy, !flt);
  endtask
  task automatic ramp(input int c0, input int c1, input int from, input int to, input int first,
                      input int tgt, input bit dir);
    for (int c = c0; c <= c1; c++) begin
      int n = c < first ? 0 : (c - first) / RD + 1;
      int d = from < to ? (from + n > to ? to : from + n) : (from - n < to ? to : from - n);
      put(c, d, dir, 1'b1, 1'b0, 1'b0, d != tgt, 1'b1);
    end
  endtask
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, got, want);
    end
  endtask
  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic cmd(input int n, input int duty, input bit dir, input bit brk);
    at(n);
    cmd_valid = 1'b1;
    cmd_duty  = 8'(duty);
    cmd_dir   = dir;
    cmd_brake = brk;
    at(n + 1);
    cmd_valid = 1'b0;
    cmd_brake = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    enc_tick = tick_en && (cyc % 10 == 0);
  end
  initial forever begin
    logic [13:0] got;
    @(negedge clk);
    got = {pwm_duty, pwm_dir, pwm_en, brake, fault, busy, cmd_ready};
    if (cyc < NC && exp_ok[cyc]) begin
      checks++;
      if (got !== exp_v[cyc]) begin
        errors++;
        $display("FAIL schedule at cycle %0d: got duty=%0d dir/en/brake/fault/busy/ready=%b want duty=%0d %b",
                 cyc, got[13:6], got[5:0], exp_v[cyc][13:6], exp_v[cyc][5:0]);
      end
    end
    if (cyc >= 80 && cyc <= 110 && !pwm_en) en_low++;
    case (cyc)
      44: begin chk("duty_pre_top", pwm_duty, 9); chk("busy_pre_top", busy, 1); end
      45: begin chk("duty_top", pwm_duty, 10); chk("busy_top", busy, 0); end
      97: chk("dir_before_flip", pwm_dir, 1);
      98: begin chk("dir_after_flip", pwm_dir, 0); chk("en_after_dead", pwm_en, 1); end
      111: chk("dead_en_low_clocks", en_low, 8);
      122: chk("duty_rev_top", pwm_duty, 6);
      136: begin chk("reset_duty", pwm_duty, 0); chk("reset_dir", pwm_dir, 1); end
      166: begin chk("brake_on", brake, 1); chk("brake_duty", pwm_duty, 0); chk("brake_en", pwm_en, 0); end
      196: chk("fault_before_trip", fault, 0);
      197: begin chk("fault_trip", fault, 1); chk("fault_ready", cmd_ready, 0); chk("fault_en", pwm_en, 0); end
      203: begin chk("clr_fault", fault, 0); chk("clr_ready", cmd_ready, 1); end
      210: chk("dropped_cmd_idle", pwm_en, 0);
      default: ;
    endcase
  end
  initial begin
    fault_cyc = (LAST_TICK > ARM_START ? LAST_TICK : ARM_START) + TO;
    still(1, 3, 1'b0, 1'b0, 1'b0);
    still(4, 4, 1'b0, 1'b0, 1'b1);
    ramp(5, 50, 0, 10, 9, 10, 1'b1);
    ramp(51, 89, 10, 0, 53, 6, 1'b1);
    still(90, 97, 1'b0, 1'b0, 1'b1);
    ramp(98, 126, 0, 6, 102, 6, 1'b0);
    ramp(127, 135, 6, 10, 130, 10, 1'b0);
    still(136, 140, 1'b0, 1'b0, 1'b0);
    still(141, 141, 1'b0, 1'b0, 1'b1);
    ramp(142, 165, 0, 8, 146, 8, 1'b1);
    still(166, 169, 1'b1, 1'b0, 1'b0);
    still(170, 170, 1'b1, 1'b0, 1'b1);
    ramp(171, 187, 0, 3, 175, 3, 1'b1);
    ramp(188, fault_cyc - 1, 3, 4, 191, 4, 1'b1);
    still(fault_cyc, 202, 1'b0, 1'b1, 1'b0);
    still(203, 212, 1'b0, 1'b0, 1'b0);
    at(2);
    rst = 1'b0;
    cmd(3, 10, 1'b1, 1'b0);
    cmd(50, 6, 1'b0, 1'b0);
    at(60);
    fault_clr = 1'b1;
    at(61);
    fault_clr = 1'b0;
    cmd(126, 10, 1'b0, 1'b0);
    at(135);
    rst = 1'b1;
    at(136);
    rst = 1'b0;
    cmd(140, 8, 1'b1, 1'b0);
    cmd(165, 200, 1'b0, 1'b1);
    cmd(169, 3, 1'b1, 1'b0);
    at(187);
    tick_en = 1'b0;
    cmd(187, 4, 1'b1, 1'b0);
    at(198);
    cmd_valid = 1'b1;
    cmd_duty  = 8'd9;
    cmd_dir   = 1'b1;
    at(200);
    cmd_valid = 1'b0;
    at(202);
    fault_clr = 1'b1;
    at(203);
    fault_clr = 1'b0;
    at(213);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
